multicycle_controller: RTL and testbench

//  Moore FSM sequencing the RISC-V datapath over multiple cycles (fetch, decode, execute,

---
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing a multi-cycle RISC-V datapath over one shared memory port
// Tracks a per-state memory-wait timeout and a retired-instruction counter.
module multicycle_controller #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             IorD,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       AluOp,
   output logic             PCSource,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             MemtoReg,
   output logic             fault,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WR = 4'd7,
      S_WB_ALU = 4'd8,
      S_WB_MEM = 4'd9,
      S_BRANCH = 4'd10,
      S_FAULT  = 4'd15
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Counter only needs to reach MEM_TIMEOUT-1; with the timeout disabled it just wraps.
   localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             wait_st;
   logic             timed_out;
   logic             retire;

   always_comb begin
      state_d   = state_q;
      instret_d = instret_q;
      to_d      = '0;
      retire    = 1'b0;
      wait_st   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
      timed_out = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (to_q == TO_LAST);
      if (wait_st && !mem_ready) begin
         to_d = to_q + 1'b1;
      end

      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_LOAD, OP_STORE: state_d = S_ADDR;
               OP_BRANCH:         state_d = S_BRANCH;
               default:           state_d = S_FAULT;
            endcase
         end
         S_EXEC_R: state_d = S_WB_ALU;
         S_EXEC_I: state_d = S_WB_ALU;
         S_ADDR:   state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
         S_MEM_WR: if (mem_ready) retire = 1'b1;
         S_WB_ALU: retire = 1'b1;
         S_WB_MEM: retire = 1'b1;
         S_BRANCH: retire = 1'b1;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_FAULT;
      endcase

      if (timed_out) begin
         state_d = S_FAULT;
      end
      if (retire) begin
         instret_d = instret_q + 1'b1;
         state_d   = run ? S_FETCH : S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         instret_q <= '0;
         to_q      <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
         to_q      <= to_d;
      end
   end

   // Moore decode; the only input gating is mem_ready/zero qualifying PC and IR loads.
   always_comb begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      ALUSrcA  = 2'b00;
      ALUSrcB  = 2'b00;
      AluOp    = 2'b00;
      PCSource = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      fault    = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
         end
         S_EXEC_R: begin
            ALUSrcA = 2'b01;
            AluOp   = 2'b10;
         end
         S_EXEC_I: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            AluOp   = 2'b11;
         end
         S_ADDR: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
         end
         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_WB_ALU: RegWrite = 1'b1;
         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 2'b01;
            AluOp    = 2'b01;
            PCSource = 1'b1;
            PCWrite  = zero;
         end
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
// Expected state paths are built per instruction class from random memory wait counts.
module tb_multicycle_controller;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          run = 1'b0;
   logic [6:0]    opcode = 7'h00;
   logic          zero = 1'b0;
   logic          mem_ready = 1'b0;
   logic          PCWrite, IRWrite, IorD, PCSource, MemRead, MemWrite, RegWrite, MemtoReg, fault;
   logic [1:0]    ALUSrcA, ALUSrcB, AluOp;
   logic [3:0]    state_o;
   logic [CW-1:0] instret;

   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] exp_ret = '0;

   typedef struct {
      int st;
      bit mr;
   } step_t;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .AluOp(AluOp), .PCSource(PCSource), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .fault(fault), .state_o(state_o),
      .instret(instret)
   );

   // Packed as {PCWrite,IRWrite,IorD,ALUSrcA,ALUSrcB,AluOp,PCSource,MemRead,MemWrite,RegWrite,MemtoReg,fault}
   logic [14:0] ctrl;
   assign ctrl = {PCWrite, IRWrite, IorD, ALUSrcA, ALUSrcB, AluOp, PCSource,
                  MemRead, MemWrite, RegWrite, MemtoReg, fault};

   function automatic logic [14:0] exp_ctrl(input int st, input bit mr, input bit z);
      logic pcw, irw, iord, pcs, mrd, mwr, rw, m2r, flt;
      logic [1:0] a, b, op;
      {pcw, irw, iord, pcs, mrd, mwr, rw, m2r, flt} = '0;
      a = 2'b00; b = 2'b00; op = 2'b00;
      case (st)
         1:  begin mrd = 1; b = 2'b01; pcw = mr; irw = mr; end
         2:  begin a = 2'b10; b = 2'b10; end
         3:  begin a = 2'b01; op = 2'b10; end
         4:  begin a = 2'b01; b = 2'b10; op = 2'b11; end
         5:  begin a = 2'b01; b = 2'b10; end
         6:  begin iord = 1; mrd = 1; end
         7:  begin iord = 1; mwr = 1; end
         8:  rw = 1;
         9:  begin rw = 1; m2r = 1; end
         10: begin a = 2'b01; op = 2'b01; pcs = 1; pcw = z; end
         15: flt = 1;
         default: ;
      endcase
      return {pcw, irw, iord, a, b, op, pcs, mrd, mwr, rw, m2r, flt};
   endfunction

   // Runs one instruction starting in FETCH; stop drops run on the retire cycle.
   task automatic drive_instr(input logic [6:0] op, input bit z, input int wf, input int wm,
                              input bit stop, input string tag);
      step_t q[$];
      bit    legal = 1'b1;
      for (int i = 0; i < wf; i++) q.push_back('{1, 1'b0});
      q.push_back('{1, 1'b1});
      q.push_back('{2, 1'($urandom)});
      case (op)
         7'h33: begin q.push_back('{3, 1'($urandom)}); q.push_back('{8, 1'($urandom)}); end
         7'h13: begin q.push_back('{4, 1'($urandom)}); q.push_back('{8, 1'($urandom)}); end
         7'h03: begin
            q.push_back('{5, 1'($urandom)});
            for (int i = 0; i < wm; i++) q.push_back('{6, 1'b0});
            q.push_back('{6, 1'b1});
            q.push_back('{9, 1'($urandom)});
         end
         7'h23: begin
            q.push_back('{5, 1'($urandom)});
            for (int i = 0; i < wm; i++) q.push_back('{7, 1'b0});
            q.push_back('{7, 1'b1});
         end
         7'h63: q.push_back('{10, 1'($urandom)});
         default: legal = 1'b0;
      endcase
      opcode = op;
      zero   = z;
      for (int i = 0; i < q.size(); i++) begin
         mem_ready = q[i].mr;
         run = (legal && i == q.size() - 1) ? !stop : 1'($urandom);
         #1;
         checks++;
         if (state_o !== 4'(q[i].st)) begin
            errors++;
            $display("FAIL %s state step %0d: got %0d want %0d", tag, i, state_o, q[i].st);
         end
         checks++;
         if (ctrl !== exp_ctrl(q[i].st, q[i].mr, z)) begin
            errors++;
            $display("FAIL %s ctrl step %0d: got %h want %h", tag, i, ctrl,
                     exp_ctrl(q[i].st, q[i].mr, z));
         end
         checks++;
         if (instret !== exp_ret) begin
            errors++;
            $display("FAIL %s instret step %0d: got %0d want %0d", tag, i, instret, exp_ret);
         end
         @(posedge clk); #1;
      end
      if (legal) exp_ret = exp_ret + 1'b1;
      run = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (state_o !== 4'd0 || ctrl !== 15'd0 || instret !== '0) begin
         errors++;
         $display("FAIL reset: state %0d ctrl %h instret %0d want 0 0 0", state_o, ctrl, instret);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (state_o !== 4'd1) begin
         errors++;
         $display("FAIL reset_release: state %0d want 1", state_o);
      end
      exp_ret = '0;
   endtask

   task automatic test_rtype;
      drive_instr(7'h33, 1'($urandom), 0, 0, 1'b0, "rtype");
      checks++;
      if (instret !== 4'd1) begin
         errors++;
         $display("FAIL rtype_instret: got %0d want 1", instret);
      end
   endtask

   task automatic test_load;
      drive_instr(7'h03, 1'b0, 0, 3, 1'b0, "load_wait3");
   endtask

   task automatic test_branch;
      drive_instr(7'h63, 1'b1, 0, 0, 1'b0, "beq_taken");
      drive_instr(7'h63, 1'b0, 0, 0, 1'b0, "beq_not_taken");
   endtask

   task automatic test_store_itype;
      drive_instr(7'h23, 1'b0, 2, 5, 1'b0, "store");
      drive_instr(7'h13, 1'b1, 1, 0, 1'b0, "itype");
   endtask

   task automatic test_timeout_edge;
      drive_instr(7'h13, 1'b0, 15, 0, 1'b0, "fetch_ready_16th");
      drive_instr(7'h03, 1'b0, 0, 15, 1'b0, "memrd_ready_16th");
      drive_instr(7'h23, 1'b0, 0, 15, 1'b0, "memwr_ready_16th");
   endtask

   task automatic test_back_to_back;
      logic [6:0] ops [5];
      ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
      for (int n = 0; n < 40; n++) begin
         int wf, wm;
         wf = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
         wm = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
         drive_instr(ops[$urandom_range(0, 4)], 1'($urandom), wf, wm, 1'b0, "b2b");
      end
   endtask

   task automatic test_run_stop;
      drive_instr(7'h33, 1'b0, 0, 0, 1'b1, "stop_rtype");
      for (int i = 0; i < 3; i++) begin
         run = 1'b0; mem_ready = 1'($urandom);
         #1;
         checks++;
         if (state_o !== 4'd0 || ctrl !== 15'd0 || instret !== exp_ret) begin
            errors++;
            $display("FAIL run_stop_idle: state %0d ctrl %h instret %0d want 0 0 %0d",
                     state_o, ctrl, instret, exp_ret);
         end
         @(posedge clk); #1;
      end
      run = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (state_o !== 4'd1) begin
         errors++;
         $display("FAIL run_restart: state %0d want 1", state_o);
      end
   endtask

   task automatic do_reset_to_fetch;
      rst = 1'b0; run = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (state_o !== 4'd0 || instret !== '0 || fault !== 1'b0) begin
         errors++;
         $display("FAIL fault_reset: state %0d instret %0d fault %0d want 0 0 0",
                  state_o, instret, fault);
      end
      exp_ret = '0;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_illegal;
      drive_instr(7'h7f, 1'b0, 0, 0, 1'b0, "illegal");
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'($urandom); run = 1'($urandom); zero = 1'($urandom);
         #1;
         checks++;
         if (state_o !== 4'd15 || ctrl !== exp_ctrl(15, 1'b0, 1'b0) || instret !== exp_ret) begin
            errors++;
            $display("FAIL illegal_sticky cyc %0d: state %0d ctrl %h instret %0d want 15 %h %0d",
                     i, state_o, ctrl, instret, exp_ctrl(15, 1'b0, 1'b0), exp_ret);
         end
         @(posedge clk); #1;
      end
      do_reset_to_fetch();
   endtask

   task automatic test_timeout_fault;
      drive_instr(7'h33, 1'b0, 0, 0, 1'b0, "pre_timeout");
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         checks++;
         if (state_o !== 4'd1) begin
            errors++;
            $display("FAIL timeout_wait cyc %0d: state %0d want 1", i, state_o);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (state_o !== 4'd15 || fault !== 1'b1 || instret !== exp_ret) begin
         errors++;
         $display("FAIL timeout_fault: state %0d fault %0d instret %0d want 15 1 %0d",
                  state_o, fault, instret, exp_ret);
      end
      do_reset_to_fetch();
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load();
      test_branch();
      test_store_itype();
      test_timeout_edge();
      test_back_to_back();
      test_run_stop();
      test_illegal();
      test_timeout_fault();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
